// File: rtl/showbullet_app.sv
// Single-bullet engine for the show-tank stage: launches one cell ahead of the tank,
// advances on step_tick, and reports a target hit or expiry at the playfield edge.
module showbullet_app #(
    parameter int X_MAX = 24,
    parameter int Y_MAX = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       step_tick,
    input  logic [4:0] tank_x,
    input  logic [4:0] tank_y,
    input  logic [1:0] tank_dir,
    input  logic       bul_sht,
    input  logic       tgt_valid,
    input  logic [4:0] tgt_x,
    input  logic [4:0] tgt_y,
    output logic [4:0] bul_x,
    output logic [4:0] bul_y,
    output logic [1:0] bul_dir,
    output logic       bul_state,
    output logic       bul_hit
);

    localparam logic [4:0] XM = 5'(X_MAX);
    localparam logic [4:0] YM = 5'(Y_MAX);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FLY  = 2'd2,
        HIT  = 2'd3
    } state_t;

    state_t     state;
    logic       sht_d;
    logic       fire;
    logic       facing_edge;
    logic       on_target;
    logic [4:0] next_x;
    logic [4:0] next_y;

    assign fire      = bul_sht & ~sht_d;
    assign on_target = tgt_valid && (bul_x == tgt_x) && (bul_y == tgt_y);

    // Edge check is evaluated before any step, so next_x/next_y never wrap.
    always_comb begin
        facing_edge = 1'b0;
        next_x      = bul_x;
        next_y      = bul_y;
        case (bul_dir)
            DIR_UP: begin
                facing_edge = (bul_y == 5'd0);
                next_y      = bul_y - 5'd1;
            end
            DIR_DOWN: begin
                facing_edge = (bul_y == YM);
                next_y      = bul_y + 5'd1;
            end
            DIR_LEFT: begin
                facing_edge = (bul_x == 5'd0);
                next_x      = bul_x - 5'd1;
            end
            DIR_RIGHT: begin
                facing_edge = (bul_x == XM);
                next_x      = bul_x + 5'd1;
            end
            default: begin
                facing_edge = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sht_d     <= 1'b0;
            bul_x     <= 5'd0;
            bul_y     <= 5'd0;
            bul_dir   <= 2'd0;
            bul_state <= 1'b0;
            bul_hit   <= 1'b0;
        end else begin
            sht_d   <= bul_sht;
            bul_hit <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && fire) begin
                        bul_x     <= tank_x;
                        bul_y     <= tank_y;
                        bul_dir   <= tank_dir;
                        bul_state <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (facing_edge) begin
                        bul_state <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        bul_x <= next_x;
                        bul_y <= next_y;
                        state <= FLY;
                    end
                end
                FLY: begin
                    if (!enable) begin
                        bul_state <= 1'b0;
                        state     <= IDLE;
                    end else if (on_target) begin
                        bul_hit <= 1'b1;
                        state   <= HIT;
                    end else if (step_tick && facing_edge) begin
                        bul_state <= 1'b0;
                        state     <= IDLE;
                    end else if (step_tick) begin
                        bul_x <= next_x;
                        bul_y <= next_y;
                    end
                end
                HIT: begin
                    bul_state <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    bul_state <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_showbullet_app.sv
// Directed bench for showbullet_app: launch, hit, edge no-launch, held fire,
// abort, async reset and disabled-target pass-through.
module tb_showbullet_app;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       step_tick;
    logic [4:0] tank_x;
    logic [4:0] tank_y;
    logic [1:0] tank_dir;
    logic       bul_sht;
    logic       tgt_valid;
    logic [4:0] tgt_x;
    logic [4:0] tgt_y;
    logic [4:0] bul_x;
    logic [4:0] bul_y;
    logic [1:0] bul_dir;
    logic       bul_state;
    logic       bul_hit;

    int total = 0;
    int bad   = 0;
    int hit_cnt = 0;

    showbullet_app #(.X_MAX(24), .Y_MAX(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .step_tick (step_tick),
        .tank_x    (tank_x),
        .tank_y    (tank_y),
        .tank_dir  (tank_dir),
        .bul_sht   (bul_sht),
        .tgt_valid (tgt_valid),
        .tgt_x     (tgt_x),
        .tgt_y     (tgt_y),
        .bul_x     (bul_x),
        .bul_y     (bul_y),
        .bul_dir   (bul_dir),
        .bul_state (bul_state),
        .bul_hit   (bul_hit)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bul_hit) hit_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_step();
        step_tick = 1'b1;
        step();
        step_tick = 1'b0;
    endtask

    task automatic set_tank(input logic [4:0] x, input logic [4:0] y, input logic [1:0] d);
        tank_x = x;
        tank_y = y;
        tank_dir = d;
    endtask

    // Fire edge is sampled on the next clk; afterwards the bullet is in LOAD.
    task automatic fire_edge();
        bul_sht = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; step_tick = 1'b0; bul_sht = 1'b0;
        tgt_valid = 1'b0; tgt_x = 5'd0; tgt_y = 5'd0;
        set_tank(5'd0, 5'd0, 2'd0);
        repeat (3) step();
        check_eq("rst_state", bul_state, 0);
        check_eq("rst_x", bul_x, 0);
        check_eq("rst_y", bul_y, 0);
        check_eq("rst_dir", bul_dir, 0);
        check_eq("rst_hit", bul_hit, 0);
        rst_n = 1'b1;
        step();

        // fire while disabled is ignored
        set_tank(5'd5, 5'd5, 2'b11);
        fire_edge();
        check_eq("dis_fire_state", bul_state, 0);
        bul_sht = 1'b0;
        step();
        enable = 1'b1;

        // launch right from (5,5), fly to x=24, expire
        fire_edge();
        check_eq("l_state_load", bul_state, 1);
        check_eq("l_cap_x", bul_x, 5);
        check_eq("l_cap_dir", bul_dir, 3);
        bul_sht = 1'b0;
        step();
        check_eq("l_first_x", bul_x, 6);
        check_eq("l_first_y", bul_y, 5);
        repeat (3) step();
        check_eq("l_hold_x", bul_x, 6);
        for (int x = 7; x <= 24; x++) begin
            tick_step();
            check_eq("l_move_x", bul_x, x);
            check_eq("l_fly_state", bul_state, 1);
        end
        tick_step();
        check_eq("l_expire_state", bul_state, 0);
        check_eq("l_expire_x", bul_x, 24);
        check_eq("l_no_hit", hit_cnt, 0);

        // hit going up from (3,10) toward target (3,7)
        tgt_valid = 1'b1; tgt_x = 5'd3; tgt_y = 5'd7;
        set_tank(5'd3, 5'd10, 2'b00);
        fire_edge();
        bul_sht = 1'b0;
        step();
        check_eq("h_first_y", bul_y, 9);
        tick_step();
        check_eq("h_y8", bul_y, 8);
        tick_step();
        check_eq("h_y7", bul_y, 7);
        check_eq("h_pre_hit", bul_hit, 0);
        step();
        check_eq("h_hit", bul_hit, 1);
        check_eq("h_hit_state", bul_state, 1);
        step();
        check_eq("h_hit_clear", bul_hit, 0);
        check_eq("h_idle_state", bul_state, 0);
        check_eq("h_hold_x", bul_x, 3);
        check_eq("h_hold_y", bul_y, 7);
        check_eq("h_hit_count", hit_cnt, 1);
        tgt_valid = 1'b0;

        // edge-facing: (0,4) left -> LOAD then IDLE
        set_tank(5'd0, 5'd4, 2'b10);
        fire_edge();
        check_eq("e_load_state", bul_state, 1);
        bul_sht = 1'b0;
        step();
        check_eq("e_idle_state", bul_state, 0);
        check_eq("e_hold_x", bul_x, 0);
        check_eq("e_hold_y", bul_y, 4);
        check_eq("e_no_hit", hit_cnt, 1);

        // held fire across a full flight launches once
        set_tank(5'd20, 5'd3, 2'b11);
        fire_edge();
        step();
        check_eq("hf_first_x", bul_x, 21);
        repeat (4) tick_step();
        check_eq("hf_expired", bul_state, 0);
        repeat (30) step();
        check_eq("hf_no_relaunch", bul_state, 0);
        check_eq("hf_hold_x", bul_x, 24);

        // re-fire after drop: launch from (10,6) right
        bul_sht = 1'b0;
        set_tank(5'd10, 5'd6, 2'b11);
        step();
        fire_edge();
        check_eq("rf_state", bul_state, 1);
        bul_sht = 1'b0;
        step();
        check_eq("rf_first_x", bul_x, 11);
        // a fire edge during FLY is ignored
        set_tank(5'd1, 5'd1, 2'b00);
        fire_edge();
        bul_sht = 1'b0;
        check_eq("rf_ignored_x", bul_x, 11);
        check_eq("rf_ignored_dir", bul_dir, 3);
        tick_step();
        check_eq("ab_x12", bul_x, 12);
        // abort with enable low at (12,6)
        enable = 1'b0;
        step();
        check_eq("ab_state", bul_state, 0);
        check_eq("ab_hold_x", bul_x, 12);
        check_eq("ab_hold_y", bul_y, 6);
        step();
        check_eq("ab_stay_idle", bul_state, 0);
        enable = 1'b1;

        // async reset mid-flight from (2,2) down
        set_tank(5'd2, 5'd2, 2'b01);
        fire_edge();
        bul_sht = 1'b0;
        step();
        check_eq("ar_first_y", bul_y, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_state", bul_state, 0);
        check_eq("ar_x", bul_x, 0);
        check_eq("ar_y", bul_y, 0);
        check_eq("ar_dir", bul_dir, 0);
        step();
        rst_n = 1'b1;
        step();

        // target disabled on path: down from (5,10), target (5,11) not valid
        tgt_valid = 1'b0; tgt_x = 5'd5; tgt_y = 5'd11;
        set_tank(5'd5, 5'd10, 2'b01);
        fire_edge();
        bul_sht = 1'b0;
        step();
        check_eq("pt_on_tgt_y", bul_y, 11);
        step();
        check_eq("pt_no_hit", bul_hit, 0);
        tick_step();
        check_eq("pt_y12", bul_y, 12);
        tick_step();
        check_eq("pt_expired", bul_state, 0);
        check_eq("pt_hit_count", hit_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
